// File: rtl/conv2d_job_sched_if.sv
// Bus bundle for the conv2d job scheduler: host job channel, engine control/address
// taps, relocated memory outputs and status.
interface conv2d_job_sched_if #(
  parameter int AW = 32,
  parameter int LW = 3
);
  // Job channel: a job transfers on a rising clock edge where job_valid_i && job_ready_o;
  // the host holds valid and the three bases stable until that edge, ready never waits on valid.
  logic          job_valid_i;
  logic          job_ready_o;
  logic [AW-1:0] job_wbase_i;
  logic [AW-1:0] job_fbase_i;
  logic [AW-1:0] job_obase_i;

  logic          eng_start_o;
  logic          eng_busy_i;
  logic [AW-1:0] eng_raddr_i;
  logic          eng_addr_is_weight_i;
  logic [AW-1:0] eng_waddr_i;
  logic          eng_wen_i;

  logic [AW-1:0] mem_raddr_o;
  logic [AW-1:0] mem_waddr_o;
  logic          mem_wen_o;
  logic          done_o;
  logic [15:0]   done_count_o;
  logic [LW-1:0] level_o;
  logic          err_timeout_o;

  modport master (
    output job_valid_i, job_wbase_i, job_fbase_i, job_obase_i,
    output eng_busy_i, eng_raddr_i, eng_addr_is_weight_i, eng_waddr_i, eng_wen_i,
    input  job_ready_o, eng_start_o, mem_raddr_o, mem_waddr_o, mem_wen_o,
    input  done_o, done_count_o, level_o, err_timeout_o
  );

  modport slave (
    input  job_valid_i, job_wbase_i, job_fbase_i, job_obase_i,
    input  eng_busy_i, eng_raddr_i, eng_addr_is_weight_i, eng_waddr_i, eng_wen_i,
    output job_ready_o, eng_start_o, mem_raddr_o, mem_waddr_o, mem_wen_o,
    output done_o, done_count_o, level_o, err_timeout_o
  );
endinterface

// File: rtl/conv2d_job_sched.sv
// Job FIFO plus launch/wait/run sequencer for the conv2d engine, relocating the engine's
// zero-based addresses onto the active job's memory regions.
module conv2d_job_sched #(
  parameter int DEPTH     = 4,
  parameter int AW        = 32,
  parameter int TO_CYCLES = 16
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  conv2d_job_sched_if.slave bus,
  output logic [2:0]        dbg_state_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = $clog2(TO_CYCLES + 1);
  localparam int JW = 3 * AW;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_RUN       = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [JW-1:0] fifo_q [DEPTH];
  logic [JW-1:0] fifo_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [AW-1:0] wbase_q, wbase_d, fbase_q, fbase_d, obase_q, obase_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [15:0]   done_cnt_q, done_cnt_d;
  logic          full, push, pop, reloc;

  // Ready depends on full only, so a pop in the same cycle never frees a slot early.
  assign full = (level_q == LW'(DEPTH));
  assign push = bus.job_valid_i && !full;
  assign pop  = (state_q == S_LAUNCH);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= S_IDLE;
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      wbase_q    <= '0;
      fbase_q    <= '0;
      obase_q    <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      done_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= fifo_d[i];
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      wbase_q    <= wbase_d;
      fbase_q    <= fbase_d;
      obase_q    <= obase_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      done_cnt_q <= done_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    done_cnt_d = done_cnt_q;
    case (state_q)
      S_IDLE:   if (level_q != '0 && !err_q) state_d = S_LAUNCH;
      S_LAUNCH: begin
        state_d = S_WAIT_BUSY;
        cnt_d   = '0;
      end
      S_WAIT_BUSY: begin
        if (bus.eng_busy_i) begin
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_d == CW'(TO_CYCLES)) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_RUN: begin
        // Count on entry to DONE so the new total is visible alongside done_o.
        if (!bus.eng_busy_i) begin
          state_d    = S_DONE;
          done_cnt_d = done_cnt_q + 16'd1;
        end
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) fifo_d[i] = fifo_q[i];
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    wbase_d  = wbase_q;
    fbase_d  = fbase_q;
    obase_d  = obase_q;
    if (push) begin
      fifo_d[wr_ptr_q] = {bus.job_wbase_i, bus.job_fbase_i, bus.job_obase_i};
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      {wbase_d, fbase_d, obase_d} = fifo_q[rd_ptr_q];
      rd_ptr_d                    = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    reloc             = (state_q == S_WAIT_BUSY) || (state_q == S_RUN);
    bus.job_ready_o   = !full;
    bus.eng_start_o   = (state_q == S_LAUNCH);
    bus.done_o        = (state_q == S_DONE);
    bus.done_count_o  = done_cnt_q;
    bus.level_o       = level_q;
    bus.err_timeout_o = err_q;
    bus.mem_raddr_o   = '0;
    bus.mem_waddr_o   = '0;
    bus.mem_wen_o     = 1'b0;
    if (reloc) begin
      bus.mem_raddr_o = bus.eng_raddr_i + (bus.eng_addr_is_weight_i ? wbase_q : fbase_q);
      bus.mem_waddr_o = bus.eng_waddr_i + obase_q;
      bus.mem_wen_o   = bus.eng_wen_i && (state_q == S_RUN);
    end
    dbg_state_o = state_q;
  end
endmodule
